// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port image buffer RAM between VGA scan-out
// reads (deadline priority) and queued draw-engine writes, one access per clk.
// A starvation guard forces a queued write through after STARVE_LIM read grants.
// Optional full-buffer clear engine is compiled in when FB_CLEAR_EN is defined.
module fb_port_arbiter #(
  parameter int FB_DEPTH   = 307200,
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = 4,
  parameter int WFIFO_D    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_gnt,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam int PTR_W = $clog2(WFIFO_D);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(FB_DEPTH);
  localparam logic [CNT_W-1:0] LIM_V = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {G_IDLE, G_RD, G_WR, G_CLR} grant_e;

  grant_e state, next_state;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_D];
  logic [PIX_W-1:0]  fifo_data [WFIFO_D];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [PIX_W-1:0]  head_data;
  logic              head_in_range, rd_in_range, rd_oor_q;
  logic [CNT_W-1:0]  starve_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_data  = fifo_data[rd_ptr[PTR_W-1:0]];
  assign head_in_range = ({1'b0, head_addr} < DEPTH_V);
  assign rd_in_range   = ({1'b0, rd_addr} < DEPTH_V);

  assign wr_ready = !fifo_full && !clear_busy;
  assign push     = wr_valid && wr_ready;
  assign pop      = (next_state == G_WR);

`ifdef FB_CLEAR_EN
  logic              busy;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_color;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  // Clear engine: sweeps every address once, ignoring restarts while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      clr_addr  <= '0;
      clr_color <= '0;
    end else if (busy) begin
      if (clr_addr == LAST_ADDR) busy <= 1'b0;
      else                       clr_addr <= clr_addr + 1'b1;
    end else if (clear_start) begin
      busy      <= 1'b1;
      clr_addr  <= '0;
      clr_color <= clear_color;
    end
  end

  assign clear_busy = busy;
`else
  assign clear_busy = 1'b0;
  wire unused_clear = ^{clear_start, clear_color};
`endif

  // Grant selection: clear, starved write, read, write, idle in that order
  always_comb begin
    next_state = G_IDLE;
    if (rst)                                           next_state = G_IDLE;
    else if (clear_busy)                               next_state = G_CLR;
    else if (!fifo_empty && (starve_cnt == LIM_V))     next_state = G_WR;
    else if (rd_req)                                   next_state = G_RD;
    else if (!fifo_empty)                              next_state = G_WR;
  end

  // RAM port steering for the access granted this cycle
  always_comb begin
    rd_gnt    = (next_state == G_RD);
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (next_state)
      G_RD: mem_addr = rd_addr;
      G_WR: begin
        mem_addr  = head_addr;
        mem_wdata = head_data;
        mem_we    = head_in_range;
      end
`ifdef FB_CLEAR_EN
      G_CLR: begin
        mem_addr  = clr_addr;
        mem_wdata = clr_color;
        mem_we    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Grant register plus out-of-range flag for the read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= G_IDLE;
      rd_oor_q <= 1'b0;
    end else begin
      state    <= next_state;
      rd_oor_q <= (next_state == G_RD) && !rd_in_range;
    end
  end

  assign rd_valid = (state == G_RD);
  assign rd_data  = (rd_valid && !rd_oor_q) ? mem_rdata : '0;

  // Starvation counter: counts reads that overtake a pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((next_state == G_WR) || fifo_empty) begin
      starve_cnt <= '0;
    end else if ((next_state == G_RD) && (starve_cnt != LIM_V)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // FIFO pointers: dropped out-of-range writes still consume their slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage, no reset needed since pointers qualify contents
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= wr_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= wr_data;
    end
  end

endmodule
